uart_cmd_parser: RTL

// Consumes received UART bytes (rx_data/rx_valid from the UART top) and assembles ASCII-hex

---
 rtl/uart_cmd_parser_if.sv | 53 +++++
 rtl/uart_cmd_parser.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser_if.sv
// Interface: uart_cmd_parser_if
//
// Groups the byte input, command handshake and error/status signals of
// uart_cmd_parser.
//   master : parser side (consumes rx bytes, produces commands/errors)
//   slave  : environment side (UART receiver + command decoder)
//
// Signals
//   i_rx_data   [7:0]            received byte, qualified by i_rx_valid
//   i_rx_valid                   1-cycle strobe per received byte
//   o_cmd_data  [CMD_WIDTH-1:0]  assembled command word, right-aligned
//   o_cmd_valid                  command pending, held until accepted
//   i_cmd_ready                  consumer accepts on o_cmd_valid & i_cmd_ready
//   o_err                        1-cycle error pulse
//   o_err_code  [1:0]            1=bad char, 2=too many digits, 3=overrun
//   o_busy                       parser is not idle

interface uart_cmd_parser_if #(
  parameter int unsigned CMD_WIDTH = 32
);

  logic [7:0]           i_rx_data;
  logic                 i_rx_valid;
  logic [CMD_WIDTH-1:0] o_cmd_data;
  logic                 o_cmd_valid;
  logic                 i_cmd_ready;
  logic                 o_err;
  logic [1:0]           o_err_code;
  logic                 o_busy;

  modport master (
    input  i_rx_data,
    input  i_rx_valid,
    input  i_cmd_ready,
    output o_cmd_data,
    output o_cmd_valid,
    output o_err,
    output o_err_code,
    output o_busy
  );

  modport slave (
    output i_rx_data,
    output i_rx_valid,
    output i_cmd_ready,
    input  o_cmd_data,
    input  o_cmd_valid,
    input  o_err,
    input  o_err_code,
    input  o_busy
  );

endinterface

// File: rtl/uart_cmd_parser.sv
// Module: uart_cmd_parser
//
// Assembles ASCII-hex command lines from received UART bytes into binary
// command words. A line of 1..NIB hex digits ended by CR or LF yields one
// command word on a valid/ready handshake. Bad characters, over-long lines
// and bytes arriving while a command is still pending raise a 1-cycle error.
//
// Ports
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : uart_cmd_parser_if.master (rx bytes, command handshake, err, busy)
//
// All outputs are registered.

module uart_cmd_parser #(
  parameter int unsigned CMD_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_cmd_parser_if.master      bus
);

  localparam int unsigned NIB   = CMD_WIDTH / 4;
  localparam int unsigned CNT_W = $clog2(NIB + 1);

  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_TOO_LONG = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e               state_q,     state_d;
  logic [CMD_WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [CMD_WIDTH-1:0] cmd_data_q,  cmd_data_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 err_q,       err_d;
  logic [1:0]           err_code_q,  err_code_d;
  logic                 busy_q,      busy_d;

  logic [7:0]           rx_byte;
  logic                 is_hex;
  logic                 is_term;
  logic [3:0]           nib;
  logic                 idle_rules;

  assign rx_byte = bus.i_rx_data;

  // Byte classification and hex digit value
  always_comb begin
    is_hex  = 1'b0;
    nib     = 4'h0;
    is_term = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nib    = 4'(rx_byte - 8'h30);
    end else if (rx_byte >= 8'h41 && rx_byte <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(rx_byte - 8'h37);
    end else if (rx_byte >= 8'h61 && rx_byte <= 8'h66) begin
      is_hex = 1'b1;
      nib    = 4'(rx_byte - 8'h57);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    idle_rules  = 1'b0;

    case (state_q)
      IDLE: begin
        idle_rules = 1'b1;
      end

      ACCUM: begin
        if (bus.i_rx_valid) begin
          if (is_hex) begin
            if (cnt_q < CNT_W'(NIB)) begin
              acc_d = (acc_q << 4) | CMD_WIDTH'(nib);
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_TOO_LONG;
              state_d    = DISCARD;
            end
          end else if (is_term) begin
            cmd_data_d  = acc_q;
            cmd_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_CHAR;
            state_d    = DISCARD;
          end
        end
      end

      // Drop the rest of a bad line silently until its terminator
      DISCARD: begin
        if (bus.i_rx_valid && is_term) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end

      HOLD: begin
        if (bus.i_cmd_ready) begin
          cmd_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = IDLE;
          // A byte in the accept cycle starts the next line immediately
          idle_rules  = 1'b1;
        end else if (bus.i_rx_valid) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // IDLE byte handling; terminators on an empty line are ignored
    if (idle_rules && bus.i_rx_valid) begin
      if (is_hex) begin
        acc_d   = CMD_WIDTH'(nib);
        cnt_d   = CNT_W'(1);
        state_d = ACCUM;
      end else if (!is_term) begin
        err_d      = 1'b1;
        err_code_d = ERR_BAD_CHAR;
        state_d    = DISCARD;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_cmd_data  = cmd_data_q;
  assign bus.o_cmd_valid = cmd_valid_q;
  assign bus.o_err       = err_q;
  assign bus.o_err_code  = err_code_q;
  assign bus.o_busy      = busy_q;

endmodule
